// File: rtl/enable_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enable_cfg_pkg
//  Description : Shared constants and FSM encoding for the RAM/bus enable
//                table loader. The enable table has 512 entries of 2 bits,
//                indexed by {rwbar, address[15:8]}. The configuration image
//                packs 4 entries per byte, LSB lane first.
//                Build option: ENABLE_TABLE_CHECKSUM_EN appends a checksum
//                byte to every image (129 bytes instead of 128).
//  Revision    : 1.0 - initial release
// ============================================================================
package enable_cfg_pkg;

    // Entry index = {rwbar, address[15:8]}
    localparam int ADDR_ENTRY_BITS  = 8;
    localparam int TABLE_ADDR_BITS  = ADDR_ENTRY_BITS + 1;
    localparam int ENTRIES_PER_BYTE = 4;

`ifdef ENABLE_TABLE_CHECKSUM_EN
    // 128 table bytes followed by one checksum byte
    localparam int IMAGE_BYTES = 129;
`else
    localparam int IMAGE_BYTES = 128;
`endif

    // Bit positions inside one 2-bit entry: {cs_ram, cs_bus}
    localparam int VAL_RAM_BIT = 1;
    localparam int VAL_BUS_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_UNPACK = 2'd2,
        ST_FINISH = 2'd3
    } t_state;

endpackage
`default_nettype wire

// File: rtl/enable_byte_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : enable_byte_unpacker
//  Description : Holds one captured image byte and walks its four 2-bit
//                lanes, LSB lane first.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_clear         - reset the lane counter (load start)
//                i_capture       - load i_byte, restart at lane 0
//                i_byte          - incoming image byte
//                i_advance       - step to the next lane
//                o_lane          - current lane index (0..3)
//                o_lane_val      - current 2-bit entry {cs_ram, cs_bus}
//                o_last_lane     - current lane is lane 3
//  Revision    : 1.0 - initial release
// ============================================================================
module enable_byte_unpacker (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_capture,
    input  logic [7:0] i_byte,
    input  logic       i_advance,
    output logic [1:0] o_lane,
    output logic [1:0] o_lane_val,
    output logic       o_last_lane
);
    import enable_cfg_pkg::*;

    logic [7:0] r_byte;
    logic [1:0] r_lane;
    logic [1:0] w_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte <= 8'h00;
            r_lane <= 2'd0;
        end else if (i_capture) begin
            r_byte <= i_byte;
            r_lane <= 2'd0;
        end else if (i_clear) begin
            r_lane <= 2'd0;
        end else if (i_advance) begin
            r_lane <= r_lane + 2'd1;   // wraps 3 -> 0 after the last lane
        end
    end

    assign w_sel = r_byte[{r_lane, 1'b0} +: 2];

    always_comb begin
        o_lane_val              = 2'b00;
        o_lane_val[VAL_RAM_BIT] = w_sel[1];
        o_lane_val[VAL_BUS_BIT] = w_sel[0];
    end

    assign o_lane      = r_lane;
    assign o_last_lane = (r_lane == 2'd3);

endmodule
`default_nettype wire

// File: rtl/enable_table_loader.sv
`default_nettype none
// ============================================================================
//  Module      : enable_table_loader
//  Description : Fills the 512 x 2-bit RAM/bus enable table from a packed
//                configuration image in external byte storage. The CPU is
//                held in reset while the table is being (re)written and is
//                released when a load completes.
//                Build option ENABLE_TABLE_CHECKSUM_EN: image carries a
//                trailing checksum byte (8-bit sum of all bytes == 0); on a
//                mismatch csum_err is raised and the CPU stays held.
//  Ports       : fpga_clk, rst          - clock, synchronous active-high reset
//                start, config_sel      - load request and image index
//                rd_req/rd_addr         - byte read request toward the source
//                rd_valid/rd_data       - byte read response
//                table_we/_write_addr/_val - enable table write port
//                cpu_hold               - CPU reset hold
//                busy, done             - status / completion pulse
//                csum_err               - checksum mismatch (option only)
//  Revision    : 1.0 - initial release
// ============================================================================
module enable_table_loader #(
    parameter int                       CONFIG_BITS     = 4,
    parameter int                       TABLE_ADDR_BITS = 9,
    parameter int                       SRC_ADDR_BITS   = 16,
    parameter logic [SRC_ADDR_BITS-1:0] IMAGE_BASE      = '0
) (
    input  logic                       fpga_clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CONFIG_BITS-1:0]     config_sel,
    output logic                       rd_req,
    output logic [SRC_ADDR_BITS-1:0]   rd_addr,
    input  logic                       rd_valid,
    input  logic [7:0]                 rd_data,
    output logic                       table_we,
    output logic [TABLE_ADDR_BITS-1:0] table_write_addr,
    output logic [1:0]                 table_val,
    output logic                       cpu_hold,
    output logic                       busy,
`ifdef ENABLE_TABLE_CHECKSUM_EN
    output logic                       done,
    output logic                       csum_err
`else
    output logic                       done
`endif
);
    import enable_cfg_pkg::*;

    localparam int c_IDX_BITS = TABLE_ADDR_BITS - $clog2(ENTRIES_PER_BYTE);

    t_state                  r_state;
    t_state                  w_next_state;
    logic [CONFIG_BITS-1:0]  r_cfg;
    logic [c_IDX_BITS-1:0]   r_byte_idx;
    logic                    r_hold;
    logic                    w_start_acc;
    logic                    w_fetch_acc;
    logic                    w_unpack;
    logic                    w_last_lane;
    logic [1:0]              w_lane;
    logic [1:0]              w_lane_val;
    logic                    w_csum_phase;
    logic                    w_csum_bad;
    logic [c_IDX_BITS:0]     w_byte_off;

    assign w_start_acc = (r_state == ST_IDLE)  && start;
    assign w_fetch_acc = (r_state == ST_FETCH) && rd_valid;
    assign w_unpack    = (r_state == ST_UNPACK);

`ifdef ENABLE_TABLE_CHECKSUM_EN
    logic       r_csum_phase;   // fetching the trailing checksum byte
    logic [7:0] r_sum;
    logic       r_csum_err;

    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            r_csum_phase <= 1'b0;
            r_sum        <= 8'h00;
            r_csum_err   <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_csum_phase <= 1'b0;
                r_sum        <= 8'h00;
                r_csum_err   <= 1'b0;
            end
            if (w_unpack && w_last_lane && (&r_byte_idx))
                r_csum_phase <= 1'b1;
            if (w_fetch_acc)
                r_sum <= r_sum + rd_data;
            if (r_state == ST_FINISH)
                r_csum_err <= w_csum_bad;
        end
    end

    assign w_csum_phase = r_csum_phase;
    // In FINISH the running sum already includes the checksum byte
    assign w_csum_bad   = (r_sum != 8'h00);
    assign csum_err     = (r_state == ST_FINISH) ? w_csum_bad : r_csum_err;
`else
    assign w_csum_phase = 1'b0;
    assign w_csum_bad   = 1'b0;
`endif

    // State register
    always_ff @(posedge fpga_clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next_state = ST_FETCH;
            ST_FETCH:  if (rd_valid)
                           w_next_state = w_csum_phase ? ST_FINISH : ST_UNPACK;
            ST_UNPACK: if (w_last_lane) begin
                           if (!(&r_byte_idx))
                               w_next_state = ST_FETCH;
`ifdef ENABLE_TABLE_CHECKSUM_EN
                           else
                               w_next_state = ST_FETCH;   // go read checksum byte
`else
                           else
                               w_next_state = ST_FINISH;
`endif
                       end
            ST_FINISH: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: image select, byte index and CPU hold
    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            r_cfg      <= '0;
            r_byte_idx <= '0;
            r_hold     <= 1'b1;
        end else begin
            if (w_start_acc) begin
                r_cfg      <= config_sel;
                r_byte_idx <= '0;
                r_hold     <= 1'b1;
            end
            // After the last byte the index wraps to 0; with the checksum
            // option {phase, idx} then addresses byte 128.
            if (w_unpack && w_last_lane)
                r_byte_idx <= r_byte_idx + 1'b1;
            if (r_state == ST_FINISH)
                r_hold <= w_csum_bad;
        end
    end

    enable_byte_unpacker u_unpacker (
        .clk         (fpga_clk),
        .rst         (rst),
        .i_clear     (w_start_acc),
        .i_capture   (w_fetch_acc),
        .i_byte      (rd_data),
        .i_advance   (w_unpack),
        .o_lane      (w_lane),
        .o_lane_val  (w_lane_val),
        .o_last_lane (w_last_lane)
    );

    assign w_byte_off = {w_csum_phase, r_byte_idx};

    assign rd_req           = (r_state == ST_FETCH);
    assign rd_addr          = IMAGE_BASE
                            + SRC_ADDR_BITS'(r_cfg) * SRC_ADDR_BITS'(IMAGE_BYTES)
                            + SRC_ADDR_BITS'(w_byte_off);
    assign table_we         = w_unpack;
    assign table_write_addr = TABLE_ADDR_BITS'({r_byte_idx, w_lane});
    assign table_val        = w_unpack ? w_lane_val : 2'b00;
    assign busy             = (r_state != ST_IDLE);
    assign done             = (r_state == ST_FINISH);
    // Release is visible in the FINISH cycle, together with done
    assign cpu_hold         = (r_state == ST_FINISH) ? w_csum_bad : r_hold;

endmodule
`default_nettype wire

// File: doc/enable_table_loader.md
Name: enable_table_loader

Overview:
- Sequencer that fills the 512-entry x 2-bit RAM/bus enable table (address-page x rwbar) from a packed configuration image held in external byte storage (SPI flash reader or BRAM).
- Selected by a config index; holds the CPU in reset while the table is inconsistent; releases it when the load completes.
- Sits between the config-select/flash-reader logic and the enable table write port (table_we / table_val / table_write_addr).

Parameters:
- CONFIG_BITS, 4, width of config_sel; number of images = 2**CONFIG_BITS.
- TABLE_ADDR_BITS, 9, table index width; entries = 512 (rwbar MSB, address[15:8] LSBs).
- SRC_ADDR_BITS, 16, byte address width toward the image source.
- IMAGE_BASE, 16'h0000, source byte address of image 0.

Ports:
- fpga_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse to begin a load; sampled only in IDLE.
- config_sel  in  CONFIG_BITS  image index; latched on accepted start.
- rd_req  out  1  byte read request; held high until rd_valid.
- rd_addr  out  SRC_ADDR_BITS  byte address = IMAGE_BASE + cfg*IMAGE_BYTES + byte_idx; stable while rd_req high.
- rd_valid  in  1  rd_data valid; accepted only when rd_req is high.
- rd_data  in  8  packed entries, 4 per byte.
- table_we  out  1  enable-table write strobe.
- table_write_addr  out  TABLE_ADDR_BITS  entry index.
- table_val  out  2  entry value {cs_ram, cs_bus}.
- cpu_hold  out  1  high = CPU held in reset.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at load completion.

Behaviour:
- Reset values: rd_req=0, rd_addr=IMAGE_BASE, table_we=0, table_write_addr=0, table_val=0, busy=0, done=0, cpu_hold=1. The CPU stays held until the first successful load.
- IMAGE_BYTES = 128 (512 entries x 2 bits / 8), or 129 with the checksum feature.
- FSM states: IDLE, FETCH, UNPACK, FINISH.
- IDLE: on start, latch config_sel, clear byte_idx (7 bits) and the lane counter, set cpu_hold=1, go to FETCH next cycle. Any start outside IDLE is ignored.
- FETCH: rd_req=1. On a cycle with rd_valid=1, capture rd_data, drop rd_req on the next cycle and go to UNPACK. rd_valid while rd_req=0 is ignored. Source latency is unbounded and there is no timeout.
- UNPACK: 4 consecutive cycles with table_we=1. Lane k (0..3) writes table_write_addr = byte_idx*4 + k and table_val = byte[2k+1:2k] (LSB lane first).
- After lane 3: if byte_idx == 127, go to FINISH; otherwise increment byte_idx and return to FETCH.
- Throughput: with zero-wait source, 5 cycles per byte; 640 cycles from start to FINISH.
- FINISH: one cycle. done=1, cpu_hold=0, go to IDLE.
- table_we is never asserted outside UNPACK. Write addresses never wrap; the last write is index 511.
- rst mid-load: return to IDLE immediately on the next edge, with all outputs at reset values and cpu_hold=1. The table may be partially written. A new start fully reloads it.
- A re-load after a completed load re-asserts cpu_hold from the start-accept cycle until FINISH.

Optional Feature:
- Macro: ENABLE_TABLE_CHECKSUM_EN.
- Defined:
  - Image is 129 bytes; byte 128 is a checksum such that the 8-bit modular sum of all 129 bytes = 8'h00.
  - After lane 3 of byte 127, FETCH byte 128 (no table writes), then FINISH.
  - Adds output csum_err (1 bit, reset 0; cleared on start-accept, set in FINISH on mismatch).
  - On mismatch, cpu_hold stays 1 after FINISH; done still pulses.
- Undefined: 128-byte image, no csum_err port, cpu_hold always released in FINISH.

Decomposition:
- Package enable_cfg_pkg holds:
  - constants ADDR_ENTRY_BITS=8, TABLE_ADDR_BITS=9, ENTRIES_PER_BYTE=4, IMAGE_BYTES;
  - FSM state encoding;
  - table_val bit positions (RAM=1, BUS=0).
- One natural sub-module, enable_byte_unpacker: holds the captured byte and 2-bit lane counter, produces lane value and last_lane. FSM, addressing and checksum stay in the top.

Test Plan:
- Zero-wait source, config_sel=3, image byte n = n[7:0]: rd_addr runs 384..511; exactly 512 table_we pulses; entry 5 (byte 1, lane 1) = 2'b00; entry 13 (byte 3, lane 1) = 2'b00, entry 12 = 2'b11; done at cycle 640 after start; cpu_hold falls with done.
- Source inserts 7 wait cycles per byte: rd_req and rd_addr stay stable through the waits; no table_we during FETCH; total = 128*(5+7) cycles.
- start pulsed again at cycle 100 of a load with config_sel changed: ignored; addresses continue from the original image; exactly one done.
- rst asserted during UNPACK of byte 40: next cycle busy=0, table_we=0, cpu_hold=1. A fresh start reloads from byte 0 and all 512 entries match the image.
- Spurious rd_valid in IDLE and in UNPACK: no state change, no extra writes.
- With ENABLE_TABLE_CHECKSUM_EN: correct checksum byte gives csum_err=0 and cpu_hold=0; checksum off by 1 gives csum_err=1, cpu_hold=1, done still pulses, 512 writes.
